// File: rtl/hd44780_responder_if.sv
// 8-bit HD44780 character-LCD bus as seen between driver (master) and display (slave).
interface hd44780_responder_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/hd44780_responder.sv
// HD44780-compatible display-side responder: 2-line DDRAM, AC, shift and scan port.
// Define READBACK_EN to support busy/AC status and DDRAM read cycles.
module hd44780_responder #(
    parameter int LINE_LEN    = 40,
    parameter int BUSY_CYCLES = 20
) (
    input  logic               clk,
    input  logic               rst,
    hd44780_responder_if.slave bus,
    input  logic [4:0]         scan_addr,
    output logic [7:0]         scan_char,
    output logic               busy,
    output logic               disp_on,
    output logic               overrun
);

    localparam int FILL_N = 2 * LINE_LEN;
    localparam int CW     = $clog2(FILL_N);
    localparam int BW     = $clog2(BUSY_CYCLES + 1);

    localparam logic [6:0] LL7    = 7'(LINE_LEN);
    localparam logic [5:0] LL6    = 6'(LINE_LEN);
    localparam logic [6:0] L1_END = LL7 - 7'd1;
    localparam logic [6:0] L2_END = 7'h40 + LL7 - 7'd1;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   fill_cnt;
    logic [BW-1:0]   busy_cnt;

    logic            e_s1;
    logic            e_s2;
    logic            e_d;
    logic            rs_l;
    logic            rw_l;
    logic [7:0]      d_l;

    logic [6:0]      ac;
    logic [5:0]      ofs;
    logic            id;
    logic            sh;
    logic [2:0]      fn;
    logic [1:0]      cb;

    logic [7:0]      mem [FILL_N];
    logic            mem_we;
    logic [CW-1:0]   mem_wa;
    logic [7:0]      mem_wd;

    logic            strobe;
    logic            wr_stb;
    logic            exec;
    logic            do_clear;
    logic            fill_last;

    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        if (a == L1_END) return 7'h40;
        if (a == L2_END) return 7'h00;
        return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        if (a == 7'h00) return L2_END;
        if (a == 7'h40) return L1_END;
        return a - 7'd1;
    endfunction

    function automatic logic [6:0] ac_set(input logic [6:0] a);
        if (a[5:0] >= LL6) return a[6] ? 7'h00 : 7'h40;
        return a;
    endfunction

    function automatic logic [5:0] ofs_inc(input logic [5:0] o);
        return (o == LL6 - 6'd1) ? 6'd0 : o + 6'd1;
    endfunction

    function automatic logic [5:0] ofs_dec(input logic [5:0] o);
        return (o == 6'd0) ? LL6 - 6'd1 : o - 6'd1;
    endfunction

    function automatic logic [CW-1:0] ddr_idx(input logic [6:0] a);
        return a[6] ? CW'(LINE_LEN) + CW'(a[5:0]) : CW'(a[5:0]);
    endfunction

    // Strobe fires on the synchronized falling edge; the bus was
    // captured on every cycle the synchronized enable was still high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1 <= 1'b0;
            e_s2 <= 1'b0;
            e_d  <= 1'b0;
            rs_l <= 1'b0;
            rw_l <= 1'b0;
            d_l  <= 8'h00;
        end else begin
            e_s1 <= bus.lcd_e;
            e_s2 <= e_s1;
            e_d  <= e_s2;
            if (e_s2) begin
                rs_l <= bus.lcd_rs;
                rw_l <= bus.lcd_rw;
                d_l  <= bus.lcd_data_in;
            end
        end
    end

    assign strobe    = e_d & ~e_s2;
    assign wr_stb    = strobe & ~rw_l;
    assign exec      = wr_stb & (state == S_IDLE);
    assign do_clear  = exec & ~rs_l & (d_l == 8'h01);
    assign fill_last = (state == S_CLEAR) && (fill_cnt == CW'(FILL_N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_CLEAR;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = (state != S_IDLE);
        unique case (state)
            S_CLEAR: if (fill_last) state_n = S_WAIT;
            S_WAIT:  if (busy_cnt == '0) state_n = S_IDLE;
            S_IDLE: begin
                if (do_clear)  state_n = S_CLEAR;
                else if (exec) state_n = S_WAIT;
            end
            default: state_n = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            busy_cnt <= '0;
        end else begin
            if (state == S_CLEAR)
                fill_cnt <= fill_last ? '0 : fill_cnt + 1'b1;
            if (fill_last || (exec && !do_clear))
                busy_cnt <= BW'(BUSY_CYCLES - 1);
            else if (state == S_WAIT && busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = ddr_idx(ac);
        mem_wd = d_l;
        if (state == S_CLEAR && !rst) begin
            mem_we = 1'b1;
            mem_wa = fill_cnt;
            mem_wd = 8'h20;
        end else if (exec && rs_l) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac      <= 7'h00;
            ofs     <= 6'd0;
            id      <= 1'b1;
            sh      <= 1'b0;
            fn      <= 3'b000;
            cb      <= 2'b00;
            disp_on <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (fill_last) begin
                ac  <= 7'h00;
                ofs <= 6'd0;
                id  <= 1'b1;
            end
            if (wr_stb && busy) overrun <= 1'b1;
            if (exec && rs_l) begin
                ac <= id ? ac_inc(ac) : ac_dec(ac);
                if (sh) ofs <= id ? ofs_inc(ofs) : ofs_dec(ofs);
            end else if (exec) begin
                unique casez (d_l)
                    8'b1???????: ac <= ac_set(d_l[6:0]);
                    8'b01??????: ;
                    8'b001?????: fn <= d_l[4:2];
                    8'b0001????: begin
                        if (d_l[3])
                            ofs <= d_l[2] ? ofs_dec(ofs) : ofs_inc(ofs);
                        else
                            ac <= d_l[2] ? ac_inc(ac) : ac_dec(ac);
                    end
                    8'b00001???: begin
                        disp_on <= d_l[2];
                        cb      <= d_l[1:0];
                    end
                    8'b000001??: begin
                        id <= d_l[1];
                        sh <= d_l[0];
                    end
                    8'b0000001?: begin
                        ac  <= 7'h00;
                        ofs <= 6'd0;
                    end
                    default: ;
                endcase
            end
`ifdef READBACK_EN
            if (strobe && rw_l && rs_l)
                ac <= id ? ac_inc(ac) : ac_dec(ac);
`endif
        end
    end

`ifdef READBACK_EN
    logic       rd_rise;
    logic [7:0] rd_data;
    logic       rd_oe;

    assign rd_rise = e_s2 & ~e_d & bus.lcd_rw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'h00;
            rd_oe   <= 1'b0;
        end else if (rd_rise) begin
            rd_oe   <= 1'b1;
            rd_data <= bus.lcd_rs ? mem[ddr_idx(ac)] : {busy, ac};
        end else if (strobe) begin
            rd_oe   <= 1'b0;
        end
    end

    assign bus.lcd_data_out = rd_data;
    assign bus.lcd_data_oe  = rd_oe;
`else
    assign bus.lcd_data_out = 8'h00;
    assign bus.lcd_data_oe  = 1'b0;
`endif

    logic [5:0]    scan_sum;
    logic [5:0]    scan_pos;
    logic [CW-1:0] scan_idx;

    always_comb begin
        scan_sum = 6'(scan_addr[3:0]) + ofs;
        scan_pos = (scan_sum >= LL6) ? scan_sum - LL6 : scan_sum;
        scan_idx = scan_addr[4] ? CW'(LINE_LEN) + CW'(scan_pos)
                                : CW'(scan_pos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scan_char <= 8'h20;
        else
            scan_char <= disp_on ? mem[scan_idx] : 8'h20;
    end

endmodule

// File: tb/tb_hd44780_responder.sv
// Randomized bench for hd44780_responder against a position-based DDRAM model.
// Build with READBACK_EN defined to also exercise status and data reads.
module tb_hd44780_responder;

    logic       clk;
    logic       rst;
    logic [4:0] scan_addr;
    logic [7:0] scan_char;
    logic       busy;
    logic       disp_on;
    logic       overrun;

    hd44780_responder_if bus();

    hd44780_responder #(
        .LINE_LEN    (40),
        .BUSY_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .scan_addr (scan_addr),
        .scan_char (scan_char),
        .busy      (busy),
        .disp_on   (disp_on),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model: DDRAM as 80 linear cells, cursor as a linear position 0..79.
    logic [7:0] m_ram [80];
    int         m_p;
    int         m_ofs;
    bit         m_id;
    bit         m_s;
    bit         m_disp;
    bit         m_ovr;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_fill();
        for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
        m_p   = 0;
        m_ofs = 0;
        m_id  = 1'b1;
    endtask

    task automatic m_reset();
        m_fill();
        m_s    = 1'b0;
        m_disp = 1'b0;
        m_ovr  = 1'b0;
    endtask

    function automatic int m_step(int p, bit up);
        return up ? (p + 1) % 80 : (p + 79) % 80;
    endfunction

    function automatic int m_ostep(int o, bit up);
        return up ? (o + 1) % 40 : (o + 39) % 40;
    endfunction

    function automatic logic [6:0] m_addr();
        return (m_p < 40) ? 7'(m_p) : 7'(64 + m_p - 40);
    endfunction

    function automatic logic [7:0] m_scan(int line, int col);
        if (!m_disp) return 8'h20;
        return m_ram[line * 40 + (col + m_ofs) % 40];
    endfunction

    task automatic m_apply(bit rs, logic [7:0] d);
        int a;
        if (rs) begin
            m_ram[m_p] = d;
            m_p = m_step(m_p, m_id);
            if (m_s) m_ofs = m_ostep(m_ofs, m_id);
        end else if (d[7]) begin
            a = int'(d[6:0]);
            if (a < 'h28)      m_p = a;
            else if (a < 'h40) m_p = 40;
            else if (a < 'h68) m_p = a - 'h40 + 40;
            else               m_p = 0;
        end else if (d[6] || d[5]) begin
            m_p = m_p;
        end else if (d[4]) begin
            if (d[3]) m_ofs = m_ostep(m_ofs, !d[2]);
            else      m_p = m_step(m_p, d[2]);
        end else if (d[3]) begin
            m_disp = d[2];
        end else if (d[2]) begin
            m_id = d[1];
            m_s  = d[0];
        end else if (d[1]) begin
            m_p   = 0;
            m_ofs = 0;
        end else if (d[0]) begin
            m_fill();
        end
    endtask

    task automatic lcd_strobe(bit rs, bit rw, logic [7:0] d, int hi);
        @(negedge clk);
        bus.lcd_rs      = rs;
        bus.lcd_rw      = rw;
        bus.lcd_data_in = d;
        @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic lcd_write(bit rs, logic [7:0] d);
        lcd_strobe(rs, 1'b0, d, $urandom_range(2, 6));
        repeat (2) @(negedge clk);
        wait_idle("idle");
        m_apply(rs, d);
    endtask

    task automatic measure_busy(output int hi);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (busy) hi++;
            else if (hi > 0) break;
        end
    endtask

    task automatic scan_get(int line, int col, output logic [7:0] v);
        @(negedge clk);
        scan_addr = 5'(line * 16 + col);
        @(negedge clk);
        v = scan_char;
    endtask

    task automatic scan_chk(int line, int col);
        logic [7:0] v;
        scan_get(line, col, v);
        check($sformatf("scan%0d_%0d", line, col), v, m_scan(line, col));
    endtask

    task automatic scan_all();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 16; c++) scan_chk(l, c);
    endtask

    task automatic release_and_count();
        int cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!busy) break;
        end
        check("boot_busy_len", cnt, 100);
    endtask

`ifdef READBACK_EN
    task automatic lcd_read(bit rs, output logic [7:0] v);
        @(negedge clk);
        bus.lcd_rs = rs;
        bus.lcd_rw = 1'b1;
        @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        v = bus.lcd_data_out;
        check("rd_oe_on", bus.lcd_data_oe, 1'b1);
        bus.lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        check("rd_oe_off", bus.lcd_data_oe, 1'b0);
        bus.lcd_rw = 1'b0;
    endtask

    task automatic status_chk(string tag, bit exp_busy);
        logic [7:0] v;
        lcd_read(1'b0, v);
        check(tag, v, {exp_busy, m_addr()});
    endtask
`endif

    initial begin
        logic [7:0] v;
        logic [7:0] d;
        int         hi;
        int         r;

        rst             = 1'b1;
        bus.lcd_e       = 1'b0;
        bus.lcd_rs      = 1'b0;
        bus.lcd_rw      = 1'b0;
        bus.lcd_data_in = 8'h00;
        scan_addr       = 5'd0;
        m_reset();

        repeat (5) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_scan", scan_char, 8'h20);
        check("rst_disp", disp_on, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_oe", bus.lcd_data_oe, 1'b0);
        check("rst_dout", bus.lcd_data_out, 8'h00);

        release_and_count();
        scan_all();

        lcd_write(1'b0, 8'h38);
        lcd_write(1'b0, 8'h0C);
        check("disp_on", disp_on, 1'b1);
        lcd_write(1'b0, 8'h06);
        lcd_write(1'b0, 8'h80);
        scan_all();

        lcd_write(1'b1, 8'h32);
        lcd_write(1'b1, 8'h30);
        lcd_write(1'b1, 8'h31);
        scan_get(0, 2, v);
        check("s2_col2", v, 8'h31);
        scan_all();
`ifdef READBACK_EN
        status_chk("s2_ac", 1'b0);
`endif

        lcd_write(1'b0, 8'hA7);
        lcd_write(1'b1, 8'h41);
        lcd_write(1'b1, 8'h42);
`ifdef READBACK_EN
        status_chk("s3_ac", 1'b0);
`endif

        repeat (5) lcd_write(1'b0, 8'h18);
        scan_chk(0, 0);
        scan_chk(0, 15);
        repeat (6) lcd_write(1'b0, 8'h1C);
        scan_get(0, 0, v);
        check("wrap_27", v, 8'h41);
        scan_get(1, 1, v);
        check("wrap_40", v, 8'h42);
        lcd_write(1'b0, 8'h18);
        repeat (40) lcd_write(1'b0, 8'h18);
        scan_get(0, 0, v);
        check("ofs_mod", v, 8'h32);
        scan_all();

`ifdef READBACK_EN
        lcd_strobe(1'b1, 1'b0, 8'h55, 3);
        repeat (2) @(negedge clk);
        m_apply(1'b1, 8'h55);
        status_chk("rd_busy_ac", 1'b1);
        wait_idle("idle");
        lcd_write(1'b0, 8'h80);
        lcd_read(1'b1, v);
        check("rd_ddram", v, 8'h32);
        m_p = m_step(m_p, m_id);
        status_chk("rd_ac_step", 1'b0);
        check("rd_no_ovr", overrun, 1'b0);
`else
        lcd_write(1'b0, 8'h80);
        lcd_strobe(1'b1, 1'b1, 8'h00, 3);
        repeat (4) @(negedge clk);
        check("rw_no_busy", busy, 1'b0);
        check("rw_oe", bus.lcd_data_oe, 1'b0);
        check("rw_dout", bus.lcd_data_out, 8'h00);
        lcd_write(1'b1, 8'h55);
        scan_chk(0, 0);
        scan_chk(0, 1);
`endif

        lcd_strobe(1'b0, 1'b0, 8'h06, 3);
        measure_busy(hi);
        check("instr_busy_len", hi, 20);
        m_apply(1'b0, 8'h06);
        wait_idle("idle");

        lcd_strobe(1'b0, 1'b0, 8'h80, 3);
        repeat (3) @(negedge clk);
        lcd_strobe(1'b1, 1'b0, 8'h77, 3);
        repeat (4) @(negedge clk);
        check("ovr_set", overrun, 1'b1);
        m_apply(1'b0, 8'h80);
        m_ovr = 1'b1;
        wait_idle("idle");
        lcd_write(1'b1, 8'h5A);
        for (int c = 0; c < 16; c++) scan_chk(0, c);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      d = 8'($urandom_range(33, 126));
            else if (r < 50) d = 8'h80 | 8'($urandom_range(0, 127));
            else if (r < 62) d = 8'h10 | 8'($urandom_range(0, 3) << 2);
            else if (r < 72) d = 8'h04 | 8'($urandom_range(0, 3));
            else if (r < 78) d = 8'h02 | 8'($urandom_range(0, 1));
            else if (r < 86) d = 8'h08 | 8'($urandom_range(0, 7));
            else if (r < 90) d = 8'h20 | 8'($urandom_range(0, 31));
            else if (r < 92) d = 8'h01;
            else             d = 8'h40 | 8'($urandom_range(0, 63));
            if (r >= 86 && r < 90 && d[2] == 1'b0) d = 8'h0C;
            lcd_write((r < 40) ? 1'b1 : 1'b0, d);
            for (int j = 0; j < 4; j++)
                scan_chk($urandom_range(0, 1), $urandom_range(0, 15));
            check("disp_model", disp_on, m_disp);
            check("ovr_sticky", overrun, m_ovr);
`ifdef READBACK_EN
            status_chk("rnd_ac", 1'b0);
`endif
        end
        lcd_write(1'b0, 8'h0C);
        scan_all();

        lcd_strobe(1'b0, 1'b0, 8'h01, 3);
        measure_busy(hi);
        check("clear_busy_len", hi, 100);
        m_apply(1'b0, 8'h01);
        wait_idle("idle");
        scan_all();

        lcd_write(1'b1, 8'h4D);
        lcd_strobe(1'b0, 1'b0, 8'h01, 3);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst2_busy", busy, 1'b1);
        check("rst2_ovr", overrun, 1'b0);
        check("rst2_disp", disp_on, 1'b0);
        m_reset();
        release_and_count();
        lcd_write(1'b0, 8'h0C);
        scan_all();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
